// File: rtl/arb_mux.sv
// N:1 valid/ready arbiter feeding a one-entry output register.
// Fixed-priority or round-robin grant selected by the RR parameter.
module arb_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int RR    = 1,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_sel
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] base;
    logic [SW-1:0] grant;
    logic          found;
    logic          space;
    logic          accept;
    int            idx;

    // Holding rst_n low also closes the input side, so nothing is accepted in reset.
    assign space  = rst_n & (~out_valid | out_ready);
    assign accept = space & found;
    assign base   = (RR != 0) ? ptr : '0;

    // Wrapped search from base; grant depends only on in_valid and the registered ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(base) + k;
            if (idx >= N) idx = idx - N;
            if (!found && in_valid[idx]) begin
                grant = SW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (accept) in_ready[grant] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            out_data  <= in_data[grant*WIDTH +: WIDTH];
            out_sel   <= grant;
            out_valid <= 1'b1;
            if (RR != 0)
                ptr <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter: WIDTH, default 16, data width per channel in bits (>=1).
REQ-002 Parameter: N, default 4, number of input channels (2..16).
REQ-003 Parameter: RR, default 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 Derived constant SW = max(1, clog2(N)), width of the grant index.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  channel i offers a word.
REQ-009 in_ready  output  N  channel i word accepted this cycle when in_valid[i] & in_ready[i].
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_valid  output  1  out_data holds a word not yet consumed.
REQ-012 out_ready  input  1  downstream consumes word when out_valid & out_ready.
REQ-013 out_sel  output  SW  registered index of the channel that supplied out_data.

Function
REQ-014 Block SHALL be a 1-entry registered N:1 selector; accepted word appears on out_data one cycle after the accepting edge.
REQ-015 Internal signal space = !out_valid | out_ready; acceptance occurs only when space = 1.
REQ-016 Grant g SHALL be computed combinationally over in_valid only; in_ready[g] = space, all other in_ready bits = 0; with no valid input, in_ready = 0.
REQ-017 in_ready SHALL NOT depend on in_data.
REQ-018 RR=0: g = lowest index i with in_valid[i] = 1.
REQ-019 RR=1: g = first index with in_valid set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-020 RR=1: on each acceptance, ptr <= (g == N-1) ? 0 : g+1; ptr unchanged when no acceptance, including when stalled.
REQ-021 On acceptance: out_data <= word of channel g, out_sel <= g, out_valid <= 1.
REQ-022 No acceptance and out_valid & out_ready: out_valid <= 0; out_data/out_sel hold last value.
REQ-023 out_valid & !out_ready (stall): out_data, out_sel, out_valid, ptr SHALL hold; in_ready = 0.
REQ-024 Simultaneous consume and accept (out_valid & out_ready & any in_valid): new word loads same edge, out_valid stays 1; sustained throughput one word per cycle, no bubble.
REQ-025 Input values and in_valid changes while in_ready = 0 SHALL have no effect on state.
REQ-026 Grant SHALL be stable within a cycle for fixed in_valid/ptr (no glitch-dependent behaviour required of the bench; purely combinational from registered ptr).
REQ-027 Non-power-of-2 N: ptr SHALL never take values >= N.

Reset
REQ-028 rst_n = 0 SHALL immediately (asynchronously) force out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
REQ-029 During reset in_ready SHALL be 0 (space forced low while rst_n = 0).
REQ-030 Reset asserted mid-stall SHALL discard the held word; after release the first acceptance follows REQ-018/019 with ptr = 0.
REQ-031 Release of rst_n is synchronised externally; block needs no internal reset synchroniser.

Verification
REQ-032 RR=1, N=4, WIDTH=16: in_valid=4'b1111 constant, out_ready=1, channel i data 16'hA000+i -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 from cycle 1 onward, no bubble.
REQ-033 RR=0, same stimulus -> out_sel = 0 every cycle; in_ready = 4'b0001 while space = 1.
REQ-034 RR=1: accept from ch2 (ptr=3), then in_valid=4'b0101 -> next grant ch0 (wrap), then ptr=1 -> ch2 granted next.
REQ-035 Stall: word from ch1 loaded, out_ready=0 for 3 cycles with in_valid=4'b1111 -> out_data/out_sel frozen, in_ready=0, ptr unchanged; out_ready=1 -> ch2 loaded same edge as consume.
REQ-036 Drain: single word from ch3, then in_valid=0, out_ready=1 -> out_valid falls after one cycle, out_sel stays 3.
REQ-037 Assert rst_n=0 mid-clock during stall with out_valid=1 -> out_valid, out_data, out_sel go 0 before next edge; after release in_valid=4'b1000 -> ch3 granted, ptr becomes 0.
